// File: rtl/ahb3lite_sram_slave.sv
// rtl/ahb3lite_sram_slave.sv - AHB3-Lite single-port SRAM slave with wait states and two-cycle ERROR
`timescale 1ns/1ps
module ahb3lite_sram_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int          IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]  WS_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [33:0] BYTE_LIMIT = 34'(MEM_DEPTH) << 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             wr_q;
    logic [3:0]       cnt_q;
    logic [31:0]      hrdata_q;
    logic [31:0]      mem [MEM_DEPTH];

    logic             take;
    logic             illegal;
    logic [3:0]       wr_be;
    logic             fetch_en;
    logic [IDX_W-1:0] fetch_idx;
    logic [31:0]      fetch_word;
    logic             unused_inputs;

    // Burst type, protection, lock and the SEQ/NONSEQ distinction do not affect this slave.
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // Lane enables for a little-endian 32-bit word.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    byte_en = 4'b0001 << lane;
            2'd1:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // An address phase is only taken in states that can start a new data phase.
    assign take = HSEL && HREADY && HTRANS[1] &&
                  (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);

    assign illegal = (HSIZE > 3'd2) ||
                     (HSIZE == 3'd1 && HADDR[0]) ||
                     (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) ||
                     (34'(HADDR) >= BYTE_LIMIT);

    assign wr_be     = (state == ST_DATA && wr_q) ? byte_en(size_q, lane_q) : 4'b0000;
    assign HREADYOUT = !(state == ST_WAIT || state == ST_ERR1);
    assign HRESP     = (state == ST_ERR1 || state == ST_ERR2);
    assign HRDATA    = hrdata_q;

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT: if (cnt_q == 4'd0) state_nxt = ST_DATA;
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (take) begin
                    if (illegal)              state_nxt = ST_ERR1;
                    else if (WAIT_STATES > 0) state_nxt = ST_WAIT;
                    else                      state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Read fetch for the next cycle's DATA, merging a write that commits on the same edge.
    always_comb begin
        fetch_en  = 1'b0;
        fetch_idx = idx_q;
        if (take && state_nxt == ST_DATA && !HWRITE) begin
            fetch_en  = 1'b1;
            fetch_idx = HADDR[IDX_W+1:2];
        end else if (state == ST_WAIT && state_nxt == ST_DATA && !wr_q) begin
            fetch_en  = 1'b1;
        end
        fetch_word = mem[fetch_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b] && fetch_idx == idx_q) fetch_word[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    // State register, captured address phase and wait counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= ST_IDLE;
            idx_q  <= '0;
            lane_q <= 2'b00;
            size_q <= 2'b00;
            wr_q   <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            state <= state_nxt;
            if (take) begin
                idx_q  <= HADDR[IDX_W+1:2];
                lane_q <= HADDR[1:0];
                size_q <= HSIZE[1:0];
                wr_q   <= HWRITE;
            end
            if (state_nxt == ST_WAIT && state != ST_WAIT) cnt_q <= WS_LOAD;
            else if (state == ST_WAIT)                    cnt_q <= cnt_q - 4'd1;
        end
    end

    // Read data register; holds its value outside read data phases.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)      hrdata_q <= 32'h0;
        else if (fetch_en) hrdata_q <= fetch_word;
    end

    // Byte-lane write commit at the edge ending a write DATA cycle.
    always_ff @(posedge HCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb/tb_ahb3lite_sram_slave.sv - scoreboard bench for ahb3lite_sram_slave
`timescale 1ns/1ps
module tb_ahb3lite_sram_slave;
    logic        HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        hresetn;
    logic        hsel;
    logic [15:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [1:0]  dsel;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        ro [3];
    logic        rs [3];
    logic [31:0] rd [3];

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        bit          is_rd;
        logic [31:0] rdata;
        bit          resp;
        int          waits;
    } exp_t;
    exp_t expq[$];

    bit pend = 0;
    int lowcnt = 0;
    bit lowresp = 0;

    // Three slaves with WAIT_STATES 0, 2, 3; dsel picks which one the bus talks to.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb3lite_sram_slave #(
            .ADDR_WIDTH (16),
            .MEM_DEPTH  (1024),
            .WAIT_STATES((g == 0) ? 0 : g + 1)
        ) u_dut (
            .HCLK     (HCLK),
            .HRESETn  (hresetn),
            .HSEL     (hsel && (dsel == 2'(g))),
            .HADDR    (haddr),
            .HWRITE   (hwrite),
            .HTRANS   (htrans),
            .HSIZE    (hsize),
            .HBURST   (3'b000),
            .HPROT    (4'b0011),
            .HMASTLOCK(1'b0),
            .HREADY   (hready),
            .HWDATA   (hwdata),
            .HRDATA   (rd[g]),
            .HREADYOUT(ro[g]),
            .HRESP    (rs[g])
        );
    end

    always_comb begin
        hready = ro[0];
        hresp  = rs[0];
        hrdata = rd[0];
        case (dsel)
            2'd1: begin hready = ro[1]; hresp = rs[1]; hrdata = rd[1]; end
            2'd2: begin hready = ro[2]; hresp = rs[2]; hrdata = rd[2]; end
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input bit is_rd, input logic [31:0] rdata,
                                input bit resp, input int waits);
        exp_t e;
        e.tag = tag; e.is_rd = is_rd; e.rdata = rdata; e.resp = resp; e.waits = waits;
        return e;
    endfunction

    // Monitor: a response phase follows every accepted address phase; compare at its final cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (!hresetn) begin
                pend = 0; lowcnt = 0; lowresp = 0;
            end else begin
                if (pend) begin
                    if (!hready) begin
                        lowcnt++;
                        lowresp |= hresp;
                    end else begin
                        if (expq.size() == 0) begin
                            chk("scoreboard_empty", 32'(expq.size()), 32'd1);
                        end else begin
                            e = expq.pop_front();
                            chk({e.tag, " waits"}, 32'(lowcnt), 32'(e.waits));
                            chk({e.tag, " hresp"}, 32'(hresp), 32'(e.resp));
                            if (e.waits > 0) chk({e.tag, " low_hresp"}, 32'(lowresp), 32'(e.resp));
                            if (e.is_rd) chk({e.tag, " hrdata"}, hrdata, e.rdata);
                        end
                        pend = 0; lowcnt = 0; lowresp = 0;
                    end
                end
                if (hsel && hready) pend = 1;
            end
        end
    end

    task automatic issue(input logic [1:0] t, input logic w, input logic [2:0] sz,
                         input logic [15:0] a, input logic [31:0] wd, input exp_t e);
        int n;
        bit ok;
        n = 0;
        hsel = 1'b1; htrans = t; hwrite = w; hsize = sz; haddr = a;
        do begin
            @(negedge HCLK);
            ok = hready;
            @(posedge HCLK);
            n++;
        end while (!ok && n < 50);
        chk({e.tag, " accept"}, 32'(ok), 32'd1);
        #1;
        hwdata = wd;
        expq.push_back(e);
    endtask

    task automatic wr(input string tag, input logic [2:0] sz, input logic [15:0] a,
                      input logic [31:0] wd, input int ws);
        issue(2'd2, 1'b1, sz, a, wd, mk(tag, 1'b0, 32'h0, 1'b0, ws));
    endtask

    task automatic rdw(input string tag, input logic [15:0] a, input logic [31:0] ex, input int ws);
        issue(2'd2, 1'b0, 3'd2, a, 32'h0, mk(tag, 1'b1, ex, 1'b0, ws));
    endtask

    task automatic bad(input string tag, input logic [2:0] sz, input logic [15:0] a);
        issue(2'd2, 1'b1, sz, a, 32'hBAD0BAD0, mk(tag, 1'b0, 32'h0, 1'b1, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        hsel = 1'b0; htrans = 2'd0;
        while (expq.size() != 0 && n < 60) begin
            @(negedge HCLK);
            n++;
        end
        chk("drain", 32'(expq.size()), 32'd0);
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        hresetn = 1'b0; hsel = 1'b0; haddr = 16'h0; hwrite = 1'b0;
        htrans = 2'd0; hsize = 3'd0; hwdata = 32'h0; dsel = 2'd0;
        repeat (3) @(posedge HCLK);
        for (int k = 0; k < 3; k++) begin
            dsel = 2'(k);
            #1;
            chk($sformatf("reset%0d hreadyout", k), 32'(hready), 32'd1);
            chk($sformatf("reset%0d hresp", k), 32'(hresp), 32'd0);
            chk($sformatf("reset%0d hrdata", k), hrdata, 32'h0);
        end
        dsel = 2'd0;
        @(posedge HCLK);
        #1 hresetn = 1'b1;
        @(posedge HCLK);
        #1;

        // IDLE beats never write; neighbours keep their values
        wr("t1 pre24", 3'd2, 16'h24, 32'h24242424, 0);
        wr("t1 pre28", 3'd2, 16'h28, 32'h28282828, 0);
        wr("t1 pre2c", 3'd2, 16'h2C, 32'h2C2C2C2C, 0);
        wr("t1 pre00", 3'd2, 16'h00, 32'h00000AAA, 0);
        wr("t1 w20", 3'd2, 16'h20, 32'h0ABBABBA, 0);
        for (int i = 0; i < 4; i++) begin
            issue(2'd0, 1'b1, 3'd2, 16'(16'h20 + 4 * i), 32'hDEADBEEF,
                  mk($sformatf("t1 idle%0d", i), 1'b0, 32'h0, 1'b0, 0));
        end
        rdw("t1 r20", 16'h20, 32'h0ABBABBA, 0);
        rdw("t1 r24", 16'h24, 32'h24242424, 0);
        rdw("t1 r28", 16'h28, 32'h28282828, 0);
        rdw("t1 r2c", 16'h2C, 32'h2C2C2C2C, 0);
        drain();

        // byte and halfword lanes
        wr("t3 w10", 3'd2, 16'h10, 32'hFFFFFFFF, 0);
        wr("t3 b12", 3'd0, 16'h12, 32'h00AA0000, 0);
        wr("t3 h10", 3'd1, 16'h10, 32'h00005555, 0);
        rdw("t3 r10", 16'h10, 32'hFFAA5555, 0);
        drain();
        rdw("t3 r10b", 16'h10, 32'hFFAA5555, 0);
        drain();

        // pipelined write then read of the same word
        wr("t4 pre08", 3'd2, 16'h08, 32'h12345678, 0);
        drain();
        wr("t4 w08", 3'd2, 16'h08, 32'hCAFEF00D, 0);
        rdw("t4 r08", 16'h08, 32'hCAFEF00D, 0);
        drain();

        // illegal transfers
        bad("t5 misalign", 3'd2, 16'h22);
        drain();
        bad("t5 range", 3'd2, 16'h1000);
        drain();
        bad("t5 size3", 3'd3, 16'h20);
        drain();
        bad("t5 half_odd", 3'd1, 16'h21);
        drain();
        rdw("t5 r20", 16'h20, 32'h0ABBABBA, 0);
        rdw("t5 r24", 16'h24, 32'h24242424, 0);
        rdw("t5 r00", 16'h00, 32'h00000AAA, 0);
        drain();

        // two wait states per data phase
        dsel = 2'd1;
        wr("t2 w40", 3'd2, 16'h40, 32'h11223344, 2);
        rdw("t2 r40", 16'h40, 32'h11223344, 2);
        drain();

        // reset during the WAIT of a write discards it
        dsel = 2'd2;
        wr("t6 pre30", 3'd2, 16'h30, 32'h30303030, 3);
        drain();
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 16'h30;
        @(negedge HCLK);
        chk("t6 addr ready", 32'(hready), 32'd1);
        @(posedge HCLK);
        #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = 32'h99999999;
        @(posedge HCLK);
        #2;
        chk("t6 in wait hreadyout", 32'(hready), 32'd0);
        hresetn = 1'b0;
        #1;
        chk("t6 rst hreadyout", 32'(hready), 32'd1);
        chk("t6 rst hresp", 32'(hresp), 32'd0);
        repeat (2) @(negedge HCLK);
        @(posedge HCLK);
        #1 hresetn = 1'b1;
        rdw("t6 r30", 16'h30, 32'h30303030, 3);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
- AHB3-Lite single-port SRAM slave. It sits directly downstream of the `ahb_if` bus driver and is the block the memory smoke tests exercise.
- Decodes address and data phases, stores 32-bit words with byte/halfword lane writes, and inserts programmable wait states.
- Returns a two-cycle ERROR for illegal transfers.
- IDLE and BUSY transfers never touch memory.

Parameters:
- ADDR_WIDTH, 16, HADDR width in bits.
- MEM_DEPTH, 1024, number of 32-bit words; legal byte range is 0 .. MEM_DEPTH*4-1.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..15).

Ports:
- HCLK  in  1  bus clock; all state changes on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  byte address.
- HWRITE  in  1  1=write, 0=read.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HSIZE  in  3  0=byte, 1=halfword, 2=word; others illegal.
- HBURST  in  3  accepted and ignored; each beat is decoded independently.
- HPROT  in  4  accepted and ignored.
- HMASTLOCK  in  1  accepted and ignored.
- HREADY  in  1  bus-level ready; an address phase is valid only when HREADY=1.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, all pending-transfer registers cleared.
  - Memory contents are not reset and are undefined after power-up.
- Address-phase capture happens on a rising edge with HSEL=1, HREADY=1, HTRANS[1]=1. Captured: HADDR, HWRITE, HSIZE.
  - Any other combination, including IDLE or BUSY with HSEL=1, gives zero-wait OKAY (HREADYOUT=1, HRESP=0) and no memory access.
- A transfer is illegal if any of the following hold:
  - HSIZE>2;
  - HSIZE=1 and HADDR[0]=1;
  - HSIZE=2 and HADDR[1:0]!=0;
  - HADDR >= MEM_DEPTH*4.
- FSM states:
  - IDLE: no data phase pending. On a legal capture go to WAIT if WAIT_STATES>0, else DATA. On an illegal capture go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 go to DATA.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes this cycle.
    - Write: HWDATA is committed at the rising edge ending DATA, with lanes enabled per HSIZE and HADDR[1:0], little-endian.
    - Read: HRDATA holds the full addressed word (all 4 bytes regardless of size).
    - Exit: a new capture in the same cycle (pipelined) re-enters WAIT, DATA or ERR1; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, no memory access. Any address phase presented during ERR1 is ignored; the master must cancel it. Go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A capture in this cycle is honoured; otherwise go to IDLE.
- Read-after-write: a read whose data phase immediately follows a write to the same word returns the merged new data. Forwarding is required when the write commits on the same edge the read's data is fetched.
- HRDATA holds its last value outside read DATA cycles.
- Back-to-back legal transfers with WAIT_STATES=0 sustain one transfer per cycle.
- HRESETn asserted mid-transfer forces the reset values immediately. A write that has not reached the end of DATA is discarded.

Test Plan:
1. Reset, NONSEQ word write 0x0ABBABBA @0x20, then 4 IDLE write beats (HWDATA=0xDEADBEEF) to 0x20..0x2C, then read @0x20 -> HRDATA=0x0ABBABBA; each IDLE beat zero-wait OKAY; 0x24..0x2C unchanged.
2. WAIT_STATES=2: write 0x11223344 @0x40 then read @0x40 -> each data phase shows exactly 2 HREADYOUT=0 cycles; read returns 0x11223344.
3. Word 0xFFFFFFFF @0x10, then byte write 0xAA to 0x12 (HWDATA=0x00AA0000), halfword write 0x5555 to 0x10 -> read @0x10 = 0xFFAA5555.
4. Pipelined write 0xCAFEF00D @0x8 followed next cycle by read @0x8, WAIT_STATES=0 -> read returns 0xCAFEF00D (forwarding); 2 transfers in 2 data cycles.
5. Illegal accesses: word @0x22 misaligned, address 0x1000 with MEM_DEPTH=1024, and HSIZE=3 -> each gets ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); memory is unmodified.
6. Assert HRESETn low during the WAIT of a write @0x30 (WAIT_STATES=3) -> HREADYOUT=1, HRESP=0 immediately; after release, @0x30 still holds its prior value.
